// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory port arbiter: FSM states, grant owner,
// access size encodings and the alignment rule.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      RESP
   } state_t;

   typedef enum logic {
      OWN_IF,
      OWN_D
   } owner_t;

   localparam logic [1:0] SZ_WORD = 2'b00;
   localparam logic [1:0] SZ_BYTE = 2'b01;
   localparam logic [1:0] SZ_HALF = 2'b10;

   // Size 2'b11 falls through to the word rule.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lsb);
      case (size)
         SZ_BYTE: is_misaligned = 1'b0;
         SZ_HALF: is_misaligned = lsb[0];
         default: is_misaligned = (lsb != 2'b00);
      endcase
   endfunction

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Saturating count of data grants made while a fetch waits; flags when the
// fetch must win the next arbitration.
module mem_arb_starve_ctr #(
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic i_inc,
   input  logic i_clr,
   output logic o_starved
);

   localparam logic [3:0] MAX_CNT = 4'(STARVE_MAX);

   logic [3:0] r_cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_inc && (r_cnt != MAX_CNT)) begin
         r_cnt <= r_cnt + 4'd1;
      end
   end

   assign o_starved = (r_cnt == MAX_CNT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Handshaked sequencer for the shared instruction/data memory: arbitrates IF
// and MEM requests, checks alignment and drives the memory strobes.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_ready,
   output logic              if_err,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [1:0]        d_size,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_ready,
   output logic              d_err,
   output logic [DATA_W-1:0] d_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_re,
   output logic              mem_we,
   output logic              mem_half,
   output logic              mem_byte,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack
);

   state_t            r_state;
   owner_t            r_owner;
   logic              r_err;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic              r_we;
   logic [1:0]        r_size;
   logic [DATA_W-1:0] r_if_rdata;
   logic [DATA_W-1:0] r_d_rdata;

   logic w_idle;
   logic w_issue;
   logic w_resp;
   logic w_starved;
   logic w_grant_d;
   logic w_grant_if;
   logic w_misaligned;

   assign w_idle  = (r_state == IDLE);
   assign w_issue = (r_state == ISSUE);
   assign w_resp  = (r_state == RESP);

   // Data wins ties unless the pending fetch has been passed over STARVE_MAX times.
   assign w_grant_d    = d_req && !(if_req && w_starved);
   assign w_grant_if   = if_req && !w_grant_d;
   assign w_misaligned = w_grant_d ? is_misaligned(d_size, d_addr[1:0])
                                   : is_misaligned(SZ_WORD, if_addr[1:0]);

   mem_arb_starve_ctr #(
      .STARVE_MAX(STARVE_MAX)
   ) u_starve (
      .clk      (clk),
      .rst      (rst),
      .i_inc    (w_idle && w_grant_d && if_req),
      .i_clr    (w_idle && w_grant_if),
      .o_starved(w_starved)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= IDLE;
         r_owner    <= OWN_IF;
         r_err      <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_we       <= 1'b0;
         r_size     <= SZ_WORD;
         r_if_rdata <= '0;
         r_d_rdata  <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_grant_d || w_grant_if) begin
                  r_owner <= w_grant_d ? OWN_D : OWN_IF;
                  if (w_misaligned) begin
                     r_err   <= 1'b1;
                     r_state <= RESP;
                  end else begin
                     r_err   <= 1'b0;
                     r_addr  <= w_grant_d ? d_addr : if_addr;
                     r_wdata <= w_grant_d ? d_wdata : '0;
                     r_we    <= w_grant_d && d_we;
                     r_size  <= w_grant_d ? d_size : SZ_WORD;
                     r_state <= ISSUE;
                  end
               end
            end
            ISSUE: begin
               if (mem_ack) begin
                  if (!r_we) begin
                     if (r_owner == OWN_IF) r_if_rdata <= mem_rdata;
                     else                   r_d_rdata  <= mem_rdata;
                  end
                  r_state <= RESP;
               end
            end
            RESP: begin
               r_err   <= 1'b0;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign mem_re    = w_issue && !r_we;
   assign mem_we    = w_issue && r_we;
   assign mem_addr  = w_issue ? r_addr : '0;
   assign mem_wdata = w_issue ? r_wdata : '0;
   assign mem_half  = w_issue && (r_size == SZ_HALF);
   assign mem_byte  = w_issue && (r_size == SZ_BYTE);

   assign if_ready = w_resp && (r_owner == OWN_IF);
   assign d_ready  = w_resp && (r_owner == OWN_D);
   assign if_err   = if_ready && r_err;
   assign d_err    = d_ready && r_err;
   assign if_rdata = r_if_rdata;
   assign d_rdata  = r_d_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a wait-state-programmable memory
// responder; expected values are hand-derived cycle numbers and data words.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        if_req = 1'b0;
   logic [31:0] if_addr = '0;
   logic        if_ready, if_err;
   logic [31:0] if_rdata;
   logic        d_req = 1'b0;
   logic        d_we = 1'b0;
   logic [1:0]  d_size = 2'b00;
   logic [31:0] d_addr = '0;
   logic [31:0] d_wdata = '0;
   logic        d_ready, d_err;
   logic [31:0] d_rdata;
   logic [31:0] mem_addr, mem_wdata;
   logic        mem_re, mem_we, mem_half, mem_byte;
   logic [31:0] mem_rdata = '0;
   logic        mem_ack;

   int nvec = 0;
   int nerr = 0;
   int mem_wait = 0;
   int wcnt = 0;

   mem_port_arbiter #(
      .ADDR_W(32),
      .DATA_W(32),
      .STARVE_MAX(4)
   ) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_err(if_err), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ready(d_ready), .d_err(d_err), .d_rdata(d_rdata),
      .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we), .mem_half(mem_half),
      .mem_byte(mem_byte), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
   );

   always #5 clk = ~clk;

   // Memory responder: acks after mem_wait stalled strobe cycles.
   assign mem_ack = (mem_re || mem_we) && (wcnt == mem_wait);
   always @(posedge clk) begin
      if (!(mem_re || mem_we) || mem_ack) wcnt <= 0;
      else                                wcnt <= wcnt + 1;
   end

   // Observes one access; cycle 1 is the first cycle after the granting edge.
   task automatic run_access(input int max_cyc, output int rdy_if_c, output int rdy_d_c,
                             output int re_c, output int we_c, output int byte_c,
                             output int half_c, output logic [31:0] seen_addr,
                             output logic [31:0] seen_wdata, output logic err_seen);
      rdy_if_c = -1; rdy_d_c = -1; re_c = 0; we_c = 0; byte_c = 0; half_c = 0;
      seen_addr = '0; seen_wdata = '0; err_seen = 1'b0;
      for (int c = 1; c <= max_cyc; c++) begin
         @(negedge clk);
         if (mem_re)   re_c++;
         if (mem_we)   we_c++;
         if (mem_byte) byte_c++;
         if (mem_half) half_c++;
         if (mem_re || mem_we) begin
            seen_addr  = mem_addr;
            seen_wdata = mem_wdata;
         end
         if (if_ready || d_ready) begin
            if (if_ready) rdy_if_c = c;
            if (d_ready)  rdy_d_c = c;
            err_seen = if_ready ? if_err : d_err;
            if_req = 1'b0;
            d_req  = 1'b0;
            @(negedge clk);
            break;
         end
      end
      if_req = 1'b0;
      d_req  = 1'b0;
   endtask

   task automatic test_reset;
      logic [135:0] outs;
      rst = 1'b0;
      if_req = 1'b1;
      if_addr = 32'h40;
      #3;
      outs = {if_ready, if_err, if_rdata, d_ready, d_err, d_rdata, mem_addr,
              mem_re, mem_we, mem_half, mem_byte, mem_wdata};
      nvec++;
      if (outs !== '0) begin
         nerr++;
         $display("FAIL reset_outputs: got %h, expected 0", outs);
      end
      repeat (2) @(negedge clk);
      nvec++;
      if (mem_re !== 1'b0 || if_ready !== 1'b0) begin
         nerr++;
         $display("FAIL reset_hold_no_grant: mem_re=%b if_ready=%b, expected 0 0", mem_re, if_ready);
      end
      if_req = 1'b0;
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_fetch_zero_wait;
      int ri, rd, re, we, by, hf;
      logic [31:0] a, wd;
      logic e;
      mem_wait = 0;
      mem_rdata = 32'h00500093;
      if_addr = 32'h40;
      if_req = 1'b1;
      run_access(10, ri, rd, re, we, by, hf, a, wd, e);
      nvec++;
      if (ri !== 2 || rd !== -1) begin
         nerr++;
         $display("FAIL fetch_ready_cycle: if_ready cycle %0d d_ready cycle %0d, expected 2 -1", ri, rd);
      end
      nvec++;
      if (re !== 1 || we !== 0 || a !== 32'h40) begin
         nerr++;
         $display("FAIL fetch_strobe: re_cycles=%0d we_cycles=%0d addr=%h, expected 1 0 00000040", re, we, a);
      end
      nvec++;
      if (if_rdata !== 32'h00500093 || e !== 1'b0) begin
         nerr++;
         $display("FAIL fetch_data: if_rdata=%h err=%b, expected 00500093 0", if_rdata, e);
      end
   endtask

   task automatic test_load_word;
      int ri, rd, re, we, by, hf;
      logic [31:0] a, wd;
      logic e;
      mem_wait = 1;
      mem_rdata = 32'hDEADBEEF;
      d_addr = 32'h200; d_size = 2'b00; d_we = 1'b0;
      d_req = 1'b1;
      run_access(10, ri, rd, re, we, by, hf, a, wd, e);
      nvec++;
      if (rd !== 3 || re !== 2 || a !== 32'h200) begin
         nerr++;
         $display("FAIL load_timing: d_ready cycle %0d re_cycles %0d addr %h, expected 3 2 00000200", rd, re, a);
      end
      nvec++;
      if (d_rdata !== 32'hDEADBEEF || if_rdata !== 32'h00500093) begin
         nerr++;
         $display("FAIL load_data: d_rdata=%h if_rdata=%h, expected deadbeef 00500093", d_rdata, if_rdata);
      end
   endtask

   task automatic test_byte_store;
      int ri, rd, re, we, by, hf;
      logic [31:0] a, wd;
      logic e;
      mem_wait = 2;
      mem_rdata = 32'h12345678;
      d_addr = 32'h103; d_size = 2'b01; d_we = 1'b1; d_wdata = 32'hAB;
      d_req = 1'b1;
      run_access(12, ri, rd, re, we, by, hf, a, wd, e);
      nvec++;
      if (rd !== 4 || e !== 1'b0) begin
         nerr++;
         $display("FAIL store_ready: d_ready cycle %0d err %b, expected 4 0", rd, e);
      end
      nvec++;
      if (we !== 3 || by !== 3 || re !== 0 || hf !== 0) begin
         nerr++;
         $display("FAIL store_strobes: we=%0d byte=%0d re=%0d half=%0d, expected 3 3 0 0", we, by, re, hf);
      end
      nvec++;
      if (a !== 32'h103 || wd !== 32'hAB) begin
         nerr++;
         $display("FAIL store_fields: addr=%h wdata=%h, expected 00000103 000000ab", a, wd);
      end
      nvec++;
      if (d_rdata !== 32'hDEADBEEF) begin
         nerr++;
         $display("FAIL store_keeps_rdata: d_rdata=%h, expected deadbeef", d_rdata);
      end
      d_we = 1'b0;
   endtask

   task automatic test_alignment;
      // {is_fetch, size, addr, expect_err}
      logic        t_if  [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      logic [1:0]  t_sz  [6] = '{2'b10, 2'b00, 2'b11, 2'b10, 2'b01, 2'b00};
      logic [31:0] t_ad  [6] = '{32'h101, 32'h42, 32'h202, 32'h102, 32'h3, 32'h204};
      logic        t_err [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      int ri, rd, re, we, by, hf, rc, exp_c;
      logic [31:0] a, wd;
      logic e;
      mem_wait = 0;
      d_we = 1'b0;
      for (int i = 0; i < 6; i++) begin
         if (t_if[i]) begin
            if_addr = t_ad[i];
            if_req = 1'b1;
         end else begin
            d_addr = t_ad[i];
            d_size = t_sz[i];
            d_req = 1'b1;
         end
         run_access(10, ri, rd, re, we, by, hf, a, wd, e);
         rc = t_if[i] ? ri : rd;
         exp_c = t_err[i] ? 1 : 2;
         nvec++;
         if (rc !== exp_c || e !== t_err[i] || re !== (t_err[i] ? 0 : 1)) begin
            nerr++;
            $display("FAIL align_%0d: ready cycle %0d err %b re_cycles %0d, expected %0d %b %0d",
                     i, rc, e, re, exp_c, t_err[i], t_err[i] ? 0 : 1);
         end
      end
   endtask

   task automatic test_starvation;
      logic [9:0] order = '0;
      logic [9:0] exp_order = 10'b10000_10000;
      int pulses = 0;
      int both = 0;
      int bad_gap = 0;
      int last_c = -1;
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      mem_wait = 0;
      d_addr = 32'h10; d_size = 2'b00; d_we = 1'b0;
      if_addr = 32'h20;
      if_req = 1'b1;
      d_req = 1'b1;
      for (int c = 1; c <= 60 && pulses < 10; c++) begin
         @(negedge clk);
         if (if_ready && d_ready) both++;
         if (if_ready || d_ready) begin
            order[pulses] = if_ready;
            if (last_c >= 0 && c - last_c != 3) bad_gap++;
            last_c = c;
            pulses++;
         end
      end
      if_req = 1'b0;
      d_req = 1'b0;
      @(negedge clk);
      nvec++;
      if (pulses !== 10 || order !== exp_order) begin
         nerr++;
         $display("FAIL starve_order: %0d pulses order %b (bit0 first, 1=IF), expected 10 %b", pulses, order, exp_order);
      end
      nvec++;
      if (both !== 0 || bad_gap !== 0) begin
         nerr++;
         $display("FAIL starve_handshake: simultaneous=%0d bad_gaps=%0d, expected 0 0", both, bad_gap);
      end
   endtask

   task automatic test_reset_mid_access;
      logic [135:0] outs;
      int spurious = 0;
      int ri, rd, re, we, by, hf;
      logic [31:0] a, wd;
      logic e;
      mem_wait = 5;
      mem_rdata = 32'hCAFEF00D;
      d_addr = 32'h300; d_size = 2'b00; d_we = 1'b0;
      d_req = 1'b1;
      repeat (2) @(negedge clk);
      nvec++;
      if (mem_re !== 1'b1) begin
         nerr++;
         $display("FAIL midrst_issue: mem_re=%b, expected 1", mem_re);
      end
      #2 rst = 1'b0;
      #1;
      outs = {if_ready, if_err, if_rdata, d_ready, d_err, d_rdata, mem_addr,
              mem_re, mem_we, mem_half, mem_byte, mem_wdata};
      nvec++;
      if (outs !== '0) begin
         nerr++;
         $display("FAIL midrst_outputs: got %h, expected 0", outs);
      end
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         if (d_ready || mem_re) spurious++;
      end
      nvec++;
      if (spurious !== 0) begin
         nerr++;
         $display("FAIL midrst_no_ready: %0d cycles with activity, expected 0", spurious);
      end
      mem_wait = 1;
      rst = 1'b1;
      run_access(12, ri, rd, re, we, by, hf, a, wd, e);
      nvec++;
      if (rd !== 3 || d_rdata !== 32'hCAFEF00D || e !== 1'b0) begin
         nerr++;
         $display("FAIL midrst_restart: d_ready cycle %0d d_rdata %h err %b, expected 3 cafef00d 0", rd, d_rdata, e);
      end
   endtask

   initial begin
      test_reset();
      test_fetch_zero_wait();
      test_load_word();
      test_byte_store();
      test_alignment();
      test_starvation();
      test_reset_mid_access();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequencing controller for the single-ported unified instruction/data memory of the pipelined RV32 core. It replaces the fixed alternating fetch/data phase scheme with request/ready handshakes, so the memory can take any number of wait cycles. It arbitrates between the IF stage (word fetch) and the MEM stage (load/store of byte, half or word), checks alignment, and returns ready pulses that the pipeline uses as stall releases. It sits between the pipeline registers and the memory module, and drives the memory's address, read/write strobes and size selects.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- STARVE_MAX, 4, consecutive data grants allowed while a fetch is pending; range 1..15
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request; held with if_addr stable until if_ready
- if_addr  in  ADDR_W  fetch address
- if_ready  out  1  one-cycle pulse: fetch complete (or faulted)
- if_err  out  1  valid with if_ready; 1 = misaligned fetch, no memory access made
- if_rdata  out  DATA_W  fetched word; holds until the next if_ready
- d_req  in  1  data request; held with d_* fields stable until d_ready
- d_we  in  1  1 = store, 0 = load
- d_size  in  2  same encoding as memsizesel: 00 word, 01 byte, 10 half; 11 is treated as word
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_ready  out  1  one-cycle pulse: data access complete (or faulted)
- d_err  out  1  valid with d_ready; 1 = misaligned access, no memory access made
- d_rdata  out  DATA_W  load data; holds until the next d_ready; unchanged by stores
- mem_addr  out  ADDR_W  memory address
- mem_re / mem_we  out  1 each  read / write strobe, held through the access
- mem_half / mem_byte  out  1 each  size selects (both 0 = word)
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid in the mem_ack cycle
- mem_ack  in  1  access complete this cycle; may arrive in the first strobe cycle (zero wait)

## Operation
- The FSM has three states: IDLE, ISSUE, RESP.
- In IDLE, with no request pending, the FSM stays in IDLE.
- Grant selection in IDLE:
  - Only one request pending: grant it.
  - Both pending: grant data, unless starve_cnt == STARVE_MAX, in which case grant fetch.
- Alignment check, applied to the granted request:
  - A fetch requires addr[1:0]==0.
  - A word data access requires addr[1:0]==0.
  - A half data access requires addr[0]==0.
  - A byte data access is always aligned.
- IDLE to ISSUE: taken on an aligned grant. The granted fields are latched into internal registers.
- IDLE to RESP: taken on a misaligned grant. The err flag is set and no memory strobe is ever raised.
- ISSUE: the memory outputs are driven from the latched fields. The strobe is held until mem_ack. On mem_ack, read data is captured into the port's rdata register (loads and fetches only), then the FSM goes to RESP.
- RESP: the granted port's ready is pulsed and err is driven with it. The FSM then goes to IDLE. The requester may still hold its request during RESP; any request seen in RESP is ignored.
- starve_cnt (4 bits):
  - Increments on a data grant made while if_req=1, saturating at STARVE_MAX.
  - Clears on any fetch grant.
  - Unchanged otherwise.
- Memory outputs outside ISSUE: mem_re=mem_we=0. mem_addr, mem_wdata and the size selects are 0.
- Reset asserted mid-access: the FSM immediately returns to IDLE and all strobes drop. An in-flight store may or may not have been committed by the memory. No ready pulse is produced for the aborted access.

## Timing
- Reset values: every output is 0, state=IDLE, starve_cnt=0, latched fields=0.
- Aligned access latency: request seen in IDLE (cycle 0), strobe asserted from cycle 1, mem_ack in cycle k≥1, ready in cycle k+1. With zero-wait memory, ready is in cycle 2.
- Misaligned access: ready (with err) in cycle 1.
- Throughput: one access per 3 cycles with zero-wait memory. The next grant is evaluated in the IDLE cycle that follows RESP.
- Outputs are registered or decoded from state only. There is no combinational path from mem_ack or any request input to any output.
- Exactly one port is served at a time. if_ready and d_ready are never high in the same cycle.

## Structure
- Package mem_arb_pkg holds:
  - the state enum (IDLE, ISSUE, RESP);
  - the size encodings (SZ_WORD=2'b00, SZ_BYTE=2'b01, SZ_HALF=2'b10);
  - a grant-owner enum (OWN_IF, OWN_D).
- One sub-module, mem_arb_starve_ctr: saturating counter with inc/clr inputs and a STARVE_MAX parameter, outputting the starved flag.
- FSM, latches and alignment check live in the top.

## Test plan
- Fetch only, zero-wait memory: if_addr=0x40 and mem_rdata=0x00500093 give mem_re high in cycle 1, if_ready in cycle 2, if_rdata=0x00500093.
- Byte store with 2 wait states: d_addr=0x103, d_size=01, d_wdata=0xAB give mem_we/mem_byte held for 3 cycles, d_ready in cycle 4, d_err=0, d_rdata unchanged.
- Misaligned half load at 0x101: d_ready and d_err=1 in cycle 1, mem_re never asserted. The same check for a word fetch at 0x42 gives if_err=1.
- if_req and d_req held continuously with STARVE_MAX=4: the grant order is D,D,D,D,IF,D,D,D,D,IF. The ready pulses are never simultaneous.
- rst asserted low during the ISSUE of a load: all outputs are 0 immediately and there is no d_ready. After rst is released with d_req still held, the access restarts and completes normally.
